// File: rtl/dmem_arbiter.sv
// Core/loader arbiter for a single-port data memory; all outputs registered, one access in flight.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; the default build gives the core fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  // ISSUE: command captured, gnt on the outputs, strobe being registered.
  // RESP: load strobe on the outputs, read data and rvalid being registered.
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              core_gnt_q, core_gnt_d;
  logic              ldr_gnt_q, ldr_gnt_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              any_req;
  logic              pick_ldr;

  assign any_req = core_req | ldr_req;

`ifdef DMEM_ARB_RR_EN
  logic last_ldr_q, last_ldr_d;

  // On a tie the loader wins only if the core was granted most recently.
  always_comb begin
    pick_ldr = ldr_req & (~core_req | ~last_ldr_q);
  end

  always_comb begin
    last_ldr_d = last_ldr_q;
    if (state_q == IDLE && any_req) begin
      last_ldr_d = pick_ldr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ldr_q <= 1'b1;
    end else begin
      last_ldr_q <= last_ldr_d;
    end
  end
`else
  always_comb begin
    pick_ldr = ldr_req & ~core_req;
  end
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    core_gnt_d    = 1'b0;
    ldr_gnt_d     = 1'b0;
    core_rvalid_d = 1'b0;
    ldr_rvalid_d  = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d    = pick_ldr;
          we_d       = pick_ldr ? ldr_we : core_we;
          addr_d     = pick_ldr ? ldr_addr : core_addr;
          wdata_d    = pick_ldr ? ldr_wdata : core_wdata;
          core_gnt_d = ~pick_ldr;
          ldr_gnt_d  = pick_ldr;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_read_d  = ~we_q;
        mem_write_d = we_q;
        state_d     = we_q ? IDLE : RESP;
      end
      RESP: begin
        // mem_rdata is valid while the read strobe is on the outputs.
        rdata_d       = mem_rdata;
        core_rvalid_d = ~owner_q;
        ldr_rvalid_d  = owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      core_gnt_q    <= 1'b0;
      ldr_gnt_q     <= 1'b0;
      core_rvalid_q <= 1'b0;
      ldr_rvalid_q  <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      core_gnt_q    <= core_gnt_d;
      ldr_gnt_q     <= ldr_gnt_d;
      core_rvalid_q <= core_rvalid_d;
      ldr_rvalid_q  <= ldr_rvalid_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  // Captured address/data feed the memory port directly; they only matter while a strobe is high.
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign rd_data     = rdata_q;
  assign core_gnt    = core_gnt_q;
  assign ldr_gnt     = ldr_gnt_q;
  assign core_rvalid = core_rvalid_q;
  assign ldr_rvalid  = ldr_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level schedule model and a reference memory.
module tb_dmem_arbiter;

  localparam int NC = 4096;

  logic       clk;
  logic       reset;
  logic       core_req, core_we, ldr_req, ldr_we;
  logic [7:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
  logic       core_gnt, core_rvalid, ldr_gnt, ldr_rvalid;
  logic [7:0] rd_data, mem_addr, mem_wdata, mem_rdata;
  logic       mem_read, mem_write;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory attached to the DUT: unwritten locations read as addr ^ 0x4A.
  logic [7:0] bmem [256];
  bit         bval [256];
  always @(posedge clk) begin
    if (mem_write) begin
      bmem[mem_addr] <= mem_wdata;
      bval[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = bval[mem_addr] ? bmem[mem_addr] : (mem_addr ^ 8'h4A);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Expected-output schedule, indexed by cycle number.
  bit       e_cg [NC], e_lg [NC], e_crv [NC], e_lrv [NC];
  bit       e_rd [NC], e_wr [NC], e_rst [NC];
  bit [7:0] e_addr [NC], e_wdata [NC], e_rval [NC];
  bit [7:0] mmem [256];
  bit [7:0] rd_model = 8'h00;
  int       next_ok = 0;
  bit       last_ldr = 1'b1;
  bit       w_ldr;
  bit       w_we;
  int       c;

  function automatic void clr(input int i);
    e_cg[i] = 0; e_lg[i] = 0; e_crv[i] = 0; e_lrv[i] = 0;
    e_rd[i] = 0; e_wr[i] = 0; e_rst[i] = 0;
    e_addr[i] = 0; e_wdata[i] = 0; e_rval[i] = 0;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = 8'(i) ^ 8'h4A;
    e_rst[1] = 1'b1;
  end

  // Compare at +1 after each rising edge, advance the model at +3 once stimulus has settled.
  always @(posedge clk) begin
    cyc = cyc + 1;
    c = cyc;
    if (c > NC - 8) begin
      $display("FAIL cycle_budget cycle=%0d got=overrun want=<%0d", c, NC - 8);
      $fatal(1, "cycle budget exhausted");
    end
    #1;
    if (e_rst[c]) rd_model = 8'h00;
    if (e_crv[c] || e_lrv[c]) rd_model = e_rval[c];
    chk("core_gnt", 32'(core_gnt), 32'(e_cg[c]));
    chk("ldr_gnt", 32'(ldr_gnt), 32'(e_lg[c]));
    chk("core_rvalid", 32'(core_rvalid), 32'(e_crv[c]));
    chk("ldr_rvalid", 32'(ldr_rvalid), 32'(e_lrv[c]));
    chk("mem_read", 32'(mem_read), 32'(e_rd[c]));
    chk("mem_write", 32'(mem_write), 32'(e_wr[c]));
    chk("rd_data", 32'(rd_data), 32'(rd_model));
    if (e_rd[c] || e_wr[c]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[c]));
    if (e_wr[c]) begin
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata[c]));
      mmem[e_addr[c]] = e_wdata[c];
    end
    if (e_rd[c]) e_rval[c+1] = mmem[e_addr[c]];
    if (e_rst[c]) begin
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    end
    #2;
    if (reset) begin
      for (int k = 1; k <= 3; k++) clr(c + k);
      e_rst[c+1] = 1'b1;
      next_ok = c + 1;
      last_ldr = 1'b1;
    end else if (c >= next_ok && (core_req || ldr_req)) begin
      if (core_req && ldr_req) begin
`ifdef DMEM_ARB_RR_EN
        w_ldr = !last_ldr;
`else
        w_ldr = 1'b0;
`endif
      end else begin
        w_ldr = ldr_req;
      end
      w_we = w_ldr ? ldr_we : core_we;
      e_cg[c+1]    = !w_ldr;
      e_lg[c+1]    = w_ldr;
      e_rd[c+2]    = !w_we;
      e_wr[c+2]    = w_we;
      e_addr[c+2]  = w_ldr ? ldr_addr : core_addr;
      e_wdata[c+2] = w_ldr ? ldr_wdata : core_wdata;
      if (!w_we) begin
        e_crv[c+3] = !w_ldr;
        e_lrv[c+3] = w_ldr;
      end
      next_ok  = c + (w_we ? 2 : 3);
      last_ldr = w_ldr;
    end
  end

  // Each step lands 2 time units after a rising edge: outputs are stable, inputs may change.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int       n;
  int       gc [4];
  bit [3:0] seq;
  bit [3:0] exp_seq;

  initial begin
    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Core load from 0x10 (initial content 0x5A).
    core_req = 1; core_we = 0; core_addr = 8'h10;
    step(); chk("t1_gnt", 32'(core_gnt), 32'd1); core_req = 0;
    step(); chk("t1_read", 32'(mem_read), 32'd1); chk("t1_addr", 32'(mem_addr), 32'h10);
    step(); chk("t1_rvalid", 32'(core_rvalid), 32'd1); chk("t1_rdata", 32'(rd_data), 32'h5A);
    step(); chk("t1_pulse", 32'(core_rvalid), 32'd0);

    // Loader store 0x33 to 0x20.
    ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 8'h33;
    step(); chk("t2_gnt", 32'(ldr_gnt), 32'd1); ldr_req = 0;
    step(); chk("t2_write", 32'(mem_write), 32'd1); chk("t2_addr", 32'(mem_addr), 32'h20);
    chk("t2_wdata", 32'(mem_wdata), 32'h33); chk("t2_noread", 32'(mem_read), 32'd0);
    step(); chk("t2_idle", 32'(mem_write), 32'd0); chk("t2_norv", 32'(ldr_rvalid), 32'd0);

    // Both requesters hold req for back-to-back stores.
    reset = 1; step(); reset = 0;
    core_req = 1; core_we = 1; core_addr = 8'h30; core_wdata = 8'hC1;
    ldr_req = 1; ldr_we = 1; ldr_addr = 8'h31; ldr_wdata = 8'hD1;
    n = 0; seq = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      step();
      if (core_gnt || ldr_gnt) begin
        seq[n] = ldr_gnt;
        gc[n] = cyc;
        n++;
        core_wdata = core_wdata + 8'd1;
        ldr_wdata = ldr_wdata + 8'd1;
        if (n == 4) begin
          core_req = 0;
          ldr_req = 0;
        end
      end
    end
    core_req = 0; ldr_req = 0;
`ifdef DMEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    chk("t3_ngnt", 32'(n), 32'd4);
    chk("t3_order", 32'(seq), 32'(exp_seq));
    if (n == 4) chk("t3_spacing", 32'(gc[3] - gc[0]), 32'd6);
    step(); step();

    // Reset in the strobe cycle of a core load aborts it.
    core_req = 1; core_we = 0; core_addr = 8'h11;
    step(); chk("t4_gnt", 32'(core_gnt), 32'd1); core_req = 0;
    step(); chk("t4_read", 32'(mem_read), 32'd1); reset = 1;
    step(); chk("t4_noread", 32'(mem_read), 32'd0); chk("t4_norv", 32'(core_rvalid), 32'd0);
    chk("t4_rd0", 32'(rd_data), 32'd0); chk("t4_addr0", 32'(mem_addr), 32'd0);
    reset = 0;
    step(); chk("t4_norv2", 32'(core_rvalid), 32'd0); chk("t4_noread2", 32'(mem_read), 32'd0);

    // Loader request during a core load waits until after core_rvalid.
    core_req = 1; core_we = 0; core_addr = 8'h12;
    step(); core_req = 0;
    step(); ldr_req = 1; ldr_we = 0; ldr_addr = 8'h13;
    step(); chk("t5_rvalid", 32'(core_rvalid), 32'd1); chk("t5_wait", 32'(ldr_gnt), 32'd0);
    step(); chk("t5_gnt", 32'(ldr_gnt), 32'd1); ldr_req = 0;
    step(); step(); step();

    // Random traffic with occasional abandoned requests and resets.
    for (int k = 0; k < 2500; k++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      if (core_req && core_gnt) begin
        core_req = ($urandom_range(0, 1) == 0);
        core_we = 1'($urandom_range(0, 1)); core_addr = 8'($urandom_range(0, 15));
        core_wdata = 8'($urandom);
      end else if (core_req) begin
        if ($urandom_range(0, 39) == 0) core_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        core_req = 1;
        core_we = 1'($urandom_range(0, 1)); core_addr = 8'($urandom_range(0, 15));
        core_wdata = 8'($urandom);
      end
      if (ldr_req && ldr_gnt) begin
        ldr_req = ($urandom_range(0, 1) == 0);
        ldr_we = 1'($urandom_range(0, 1)); ldr_addr = 8'($urandom_range(0, 15));
        ldr_wdata = 8'($urandom);
      end else if (ldr_req) begin
        if ($urandom_range(0, 39) == 0) ldr_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        ldr_req = 1;
        ldr_we = 1'($urandom_range(0, 1)); ldr_addr = 8'($urandom_range(0, 15));
        ldr_wdata = 8'($urandom);
      end
    end
    core_req = 0; ldr_req = 0; reset = 0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
